// File: rtl/experiment_cmd_decoder.sv
// rtl/experiment_cmd_decoder.sv - host byte-stream command decoder for the aging-sensor experiment frame
// Optional payload inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module experiment_cmd_decoder #(
    parameter int NUM_MODULES    = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int SEL_W         = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [15:0]      xin,
    output logic [15:0]      yin,
    output logic             trigger_measurement,
    input  logic [19:0]      rout,
    input  logic [31:0]      aging_sensor_value,
    input  logic             ready,
    output logic [SEL_W-1:0] module_sel,
    output logic             cmd_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_IDX, S_GET_HI, S_GET_LO, S_GET_SEL, S_SEND, S_TRIG
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_shift;
    logic [2:0]  r_left;
    logic [7:0]  r_hi;
    logic        r_tgt_y;
    logic        r_idx_bad;
    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_in_payload;
    logic        w_timeout;

    assign w_in_payload = (r_state == S_GET_IDX) || (r_state == S_GET_HI) ||
                          (r_state == S_GET_LO)  || (r_state == S_GET_SEL);
    assign rx_ready            = w_in_payload || (r_state == S_IDLE);
    assign tx_valid            = (r_state == S_SEND);
    assign tx_data             = (r_state == S_SEND) ? r_shift[31:24] : 8'h00;
    assign trigger_measurement = (r_state == S_TRIG);
    assign w_rx_fire           = rx_valid && rx_ready;
    assign w_tx_fire           = tx_valid && tx_ready;

`ifdef CMD_TIMEOUT_EN
    logic [31:0] r_wait_cnt;

    // Restarts on every accepted byte; IDLE keeps it parked at zero.
    always_ff @(posedge clk) begin
        if (rst || !w_in_payload || w_rx_fire) begin
            r_wait_cnt <= 32'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign w_timeout = w_in_payload && !w_rx_fire && (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    case (rx_data)
                        8'd0:             w_next = S_GET_IDX;
                        8'd2, 8'd4, 8'd5: w_next = S_SEND;
                        8'd3:             w_next = S_TRIG;
                        8'd6:             w_next = S_GET_SEL;
                        default:          w_next = S_IDLE;
                    endcase
                end
            end
            S_GET_IDX: if (w_rx_fire) w_next = S_GET_HI;
            S_GET_HI:  if (w_rx_fire) w_next = S_GET_LO;
            S_GET_LO:  if (w_rx_fire) w_next = S_IDLE;
            S_GET_SEL: if (w_rx_fire) w_next = S_IDLE;
            S_SEND:    if (w_tx_fire && (r_left == 3'd1)) w_next = S_IDLE;
            S_TRIG:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= 32'd0;
            r_left     <= 3'd0;
            r_hi       <= 8'd0;
            r_tgt_y    <= 1'b0;
            r_idx_bad  <= 1'b0;
            xin        <= 16'd0;
            yin        <= 16'd0;
            module_sel <= '0;
            cmd_error  <= 1'b0;
        end else begin
            if (w_timeout) begin
                cmd_error <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    // Response words are left-aligned so the MSB byte is always r_shift[31:24].
                    if (w_rx_fire) begin
                        case (rx_data)
                            8'd2: begin
                                r_shift <= {4'h0, rout, 8'h00};
                                r_left  <= 3'd3;
                            end
                            8'd4: begin
                                r_shift <= {7'b0, ready, 24'h0};
                                r_left  <= 3'd1;
                            end
                            8'd5: begin
                                r_shift <= aging_sensor_value;
                                r_left  <= 3'd4;
                            end
                            8'd0, 8'd3, 8'd6: ;
                            default: cmd_error <= 1'b1;
                        endcase
                    end
                end
                S_GET_IDX: begin
                    if (w_rx_fire) begin
                        r_tgt_y   <= (rx_data == 8'd1);
                        r_idx_bad <= (rx_data > 8'd1);
                        if (rx_data > 8'd1) begin
                            cmd_error <= 1'b1;
                        end
                    end
                end
                S_GET_HI: if (w_rx_fire) r_hi <= rx_data;
                S_GET_LO: begin
                    if (w_rx_fire && !r_idx_bad) begin
                        if (r_tgt_y) begin
                            yin <= {r_hi, rx_data};
                        end else begin
                            xin <= {r_hi, rx_data};
                        end
                    end
                end
                S_GET_SEL: begin
                    if (w_rx_fire) begin
                        if (int'({24'h0, rx_data}) < NUM_MODULES) begin
                            module_sel <= rx_data[SEL_W-1:0];
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (w_tx_fire) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_left  <= r_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
